top: RTL and testbench
======================

// Module: top
// PURPOSE
//  - Registered, op-selectable two-operand bitwise logic unit: y = f(a, b) each clock.
//  - Top-level leaf for the gate exercises; default function is 2-input AND.
//  - Also counts rising events on the result for bench and debug visibility.
// PARAMETERS
//  - WIDTH   1   operand/result width in bits (>=1)
//  - CNT_W   8   width of rise-event counter (>=2)
// PORTS
//  - clk         in   1        rising-edge clock
//  - rst         in   1        asynchronous reset, active-high
//  - a           in   WIDTH    operand A
//  - b           in   WIDTH    operand B
//  - op          in   3        function select (table below)
//  - cnt_clr     in   1        synchronous clear of rise counter
//  - y           out  WIDTH    registered result
//  - y_rise_cnt  out  CNT_W    count of cycles in which any y bit rose 0->1
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is asynchronous, active-high.
//  - op encoding (bitwise, per bit i):
//    - 000 AND, 001 OR, 010 XOR, 011 NAND
//    - 100 NOR, 101 XNOR, 110 pass A, 111 NOT A
//  - All 8 codes are defined; no reserved values.
//  - At each rising clk: y <= f_op(a, b).
//    - Latency: 1 cycle from a/b/op sampled to y.
//    - An op change takes effect with the operands sampled at the same edge.
//  - Outputs are registers only; no combinational path from inputs to outputs.
//  - Rise detect:
//    - rise = |(y_next & ~y): any bit of y transitions 0->1 at this edge.
//  - Counter rules, in priority order:
//    - cnt_clr=1 -> y_rise_cnt <= 0. Clear wins over a simultaneous rise.
//    - else rise=1 and count < max -> increment.
//    - at 2^CNT_W-1 -> saturate, no wrap.
//  - Multiple bits rising in one cycle count as one event.
//  - Reset (async assert, any time incl. mid-operation):
//    - y = 0, y_rise_cnt = 0, internal sync flops = 0.
//  - First edge after rst deasserts:
//    - y=0 before that edge, so a nonzero result counts as a rise.
//  - X/undriven inputs are not filtered; the bench drives a, b and op only with known values.
// CONFIGURATION
//  - Macro TOP_INPUT_SYNC_EN:
//    - Defined: a and b each pass through a 2-flop synchronizer (reset to 0) before the logic function.
//      - a/b-to-y latency is 3 cycles.
//      - op and cnt_clr are not synchronized (1 cycle).
//      - For asynchronous switch/pin inputs.
//    - Undefined: no synchronizer; a/b-to-y latency is 1 cycle.
//  - The counter and the op table are identical in both builds.
// TESTING
//  - Default build, WIDTH=1, op=000, 10-cycle steps, (a,b) = (1,1),(0,1),(0,0),(1,0):
//    - y = 1,0,0,0, each one cycle after the step.
//    - y_rise_cnt = 1.
//  - op sweep with a=1,b=0 (one op per cycle):
//    - y = 0,1,1,1,0,0,1,0 for op 000..111.
//  - WIDTH=4, a=4'b1100, b=4'b1010:
//    - op=010 -> y=4'b0110.
//    - op=101 -> y=4'b1001.
//  - Counter:
//    - CNT_W=2, toggle y 0->1 five times -> count 1,2,3,3,3 (saturates).
//    - cnt_clr=1 on a rise cycle -> count 0.
//  - Reset: assert rst mid-cycle while y=1, cnt=2 -> y=0 and cnt=0 immediately, before the next clk edge.
//  - TOP_INPUT_SYNC_EN defined, a,b 0->1 with op=000:
//    - y rises exactly 3 clk edges later.
//    - Macro undefined: y rises 1 edge later.

Source files
------------

// File: rtl/top.sv
// top: registered op-selectable bitwise logic unit with saturating rise-event counter.
// Define TOP_INPUT_SYNC_EN to pass a and b through 2-flop synchronizers (a/b-to-y latency 3).
module top #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] y,
   output logic [CNT_W-1:0] y_rise_cnt
);
   logic [WIDTH-1:0] a_in, b_in, y_next;
   logic             rise;
`ifdef TOP_INPUT_SYNC_EN
   logic [WIDTH-1:0] a_s1, a_s2, b_s1, b_s2;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_s1 <= '0;
         a_s2 <= '0;
         b_s1 <= '0;
         b_s2 <= '0;
      end else begin
         a_s1 <= a;
         a_s2 <= a_s1;
         b_s1 <= b;
         b_s2 <= b_s1;
      end
   assign a_in = a_s2;
   assign b_in = b_s2;
`else
   assign a_in = a;
   assign b_in = b;
`endif
   always_comb begin
      y_next = op == 3'd0 ? a_in & b_in :
               op == 3'd1 ? a_in | b_in :
               op == 3'd2 ? a_in ^ b_in :
               op == 3'd3 ? ~(a_in & b_in) :
               op == 3'd4 ? ~(a_in | b_in) :
               op == 3'd5 ? ~(a_in ^ b_in) :
               op == 3'd6 ? a_in : ~a_in;
      rise = |(y_next & ~y);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         y <= '0;
         y_rise_cnt <= '0;
      end else begin
         y <= y_next;
         y_rise_cnt <= cnt_clr ? '0 :
                       (rise && y_rise_cnt != {CNT_W{1'b1}}) ? y_rise_cnt + 1'b1 : y_rise_cnt;
      end
endmodule

// File: tb/tb_top.sv
// tb_top: table vectors, hand sequences and random stimulus against a behavioural model of top.
module tb_top;
`ifdef TOP_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic a1, b1, clr1, y1;
   logic [2:0] op1, op4;
   logic [7:0] c1;
   logic [3:0] a4, b4, y4;
   logic clr4;
   logic [1:0] c4;
   int pass = 0, total = 0;
   logic ha1 [3], hb1 [3];
   logic [3:0] ha4 [3], hb4 [3];
   logic [3:0] m_y1, m_y4;
   int m_c1, m_c4;

   typedef struct {
      logic       w4;
      logic [3:0] a, b;
      logic [2:0] op;
      int         hold;
      logic [3:0] y;
   } vec_t;
   vec_t vt [14];

   top #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .op(op1),
      .cnt_clr(clr1), .y(y1), .y_rise_cnt(c1));
   top #(.WIDTH(4), .CNT_W(2)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .op(op4),
      .cnt_clr(clr4), .y(y4), .y_rise_cnt(c4));

   always #5 clk = ~clk;

   function automatic logic [3:0] fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return ~(a ^ b);
         3'd6: return a;
         default: return ~a;
      endcase
   endfunction

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask

   task automatic mreset();
      for (int i = 0; i < 3; i++) begin
         ha1[i] = 1'b0; hb1[i] = 1'b0; ha4[i] = 4'h0; hb4[i] = 4'h0;
      end
      m_y1 = 4'h0; m_y4 = 4'h0; m_c1 = 0; m_c4 = 0;
   endtask

   // one clock edge: advance the model with the inputs present at the edge, then compare
   task automatic tick();
      logic [3:0] ny1, ny4;
      @(posedge clk);
      for (int i = 2; i > 0; i--) begin
         ha1[i] = ha1[i-1]; hb1[i] = hb1[i-1]; ha4[i] = ha4[i-1]; hb4[i] = hb4[i-1];
      end
      ha1[0] = a1; hb1[0] = b1; ha4[0] = a4; hb4[0] = b4;
      ny1 = fn(op1, {3'b0, ha1[LAT-1]}, {3'b0, hb1[LAT-1]}) & 4'h1;
      ny4 = fn(op4, ha4[LAT-1], hb4[LAT-1]);
      if (clr1) m_c1 = 0;
      else if ((ny1 & ~m_y1) != 0) m_c1 = m_c1 < 255 ? m_c1 + 1 : 255;
      if (clr4) m_c4 = 0;
      else if ((ny4 & ~m_y4) != 0) m_c4 = m_c4 < 3 ? m_c4 + 1 : 3;
      m_y1 = ny1;
      m_y4 = ny4;
      #1;
      check("y1", {31'b0, y1}, {28'b0, m_y1});
      check("cnt1", {24'b0, c1}, m_c1);
      check("y4", {28'b0, y4}, {28'b0, m_y4});
      check("cnt4", {30'b0, c4}, m_c4);
   endtask

   task automatic hard_reset();
      @(negedge clk);
      rst = 1'b1;
      mreset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      a1 = 0; b1 = 0; op1 = 0; clr1 = 0; a4 = 0; b4 = 0; op4 = 0; clr4 = 0;
      mreset();
      #1;
      check("rst_y1", {31'b0, y1}, 0);
      check("rst_cnt1", {24'b0, c1}, 0);
      check("rst_y4", {28'b0, y4}, 0);
      check("rst_cnt4", {30'b0, c4}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      vt[0]  = '{0, 4'h1, 4'h1, 3'd0, 10, 4'h1};
      vt[1]  = '{0, 4'h0, 4'h1, 3'd0, 10, 4'h0};
      vt[2]  = '{0, 4'h0, 4'h0, 3'd0, 10, 4'h0};
      vt[3]  = '{0, 4'h1, 4'h0, 3'd0, 10, 4'h0};
      vt[4]  = '{0, 4'h1, 4'h0, 3'd0, LAT, 4'h0};
      vt[5]  = '{0, 4'h1, 4'h0, 3'd1, LAT, 4'h1};
      vt[6]  = '{0, 4'h1, 4'h0, 3'd2, LAT, 4'h1};
      vt[7]  = '{0, 4'h1, 4'h0, 3'd3, LAT, 4'h1};
      vt[8]  = '{0, 4'h1, 4'h0, 3'd4, LAT, 4'h0};
      vt[9]  = '{0, 4'h1, 4'h0, 3'd5, LAT, 4'h0};
      vt[10] = '{0, 4'h1, 4'h0, 3'd6, LAT, 4'h1};
      vt[11] = '{0, 4'h1, 4'h0, 3'd7, LAT, 4'h0};
      vt[12] = '{1, 4'hC, 4'hA, 3'd2, LAT, 4'h6};
      vt[13] = '{1, 4'hC, 4'hA, 3'd5, LAT, 4'h9};
      for (int i = 0; i < 14; i++) begin
         if (vt[i].w4) begin
            a4 = vt[i].a; b4 = vt[i].b; op4 = vt[i].op;
         end else begin
            a1 = vt[i].a[0]; b1 = vt[i].b[0]; op1 = vt[i].op;
         end
         repeat (vt[i].hold) tick();
         check($sformatf("vec%0d", i), vt[i].w4 ? {28'b0, y4} : {31'b0, y1}, {28'b0, vt[i].y});
         if (i == 3) check("and_seq_cnt", {24'b0, c1}, 1);
      end

      // saturation of the 2-bit counter, then clear colliding with a rise
      a4 = 0; b4 = 0; op4 = 3'd6;
      hard_reset();
      for (int k = 0; k < 5; k++) begin
         a4 = 4'hF;
         repeat (LAT) tick();
         check($sformatf("sat%0d", k), {30'b0, c4}, k < 3 ? k + 1 : 3);
         a4 = 4'h0;
         repeat (LAT) tick();
      end
      a4 = 4'hF;
      repeat (LAT - 1) tick();
      clr4 = 1'b1;
      tick();
      clr4 = 1'b0;
      check("clr_on_rise_cnt", {30'b0, c4}, 0);
      check("clr_on_rise_y", {28'b0, y4}, 4'hF);

      // asynchronous reset mid-cycle with y=1, cnt=2
      a1 = 0; b1 = 0; op1 = 3'd6;
      hard_reset();
      a1 = 1; repeat (LAT) tick();
      a1 = 0; repeat (LAT) tick();
      a1 = 1; repeat (LAT) tick();
      check("pre_rst_cnt", {24'b0, c1}, 2);
      check("pre_rst_y", {31'b0, y1}, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_y", {31'b0, y1}, 0);
      check("async_rst_cnt", {24'b0, c1}, 0);
      mreset();
      @(negedge clk);
      rst = 1'b0;

      // a/b-to-y latency
      a1 = 0; b1 = 0; op1 = 3'd0;
      hard_reset();
      a1 = 1; b1 = 1;
      n = 0;
      while (y1 !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("latency", n, LAT);

      hard_reset();
      repeat (3000) begin
         a1 = 1'($urandom); b1 = 1'($urandom); op1 = 3'($urandom);
         a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom);
         clr1 = $urandom_range(0, 999) == 0;
         clr4 = $urandom_range(0, 19) == 0;
         tick();
      end
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
